// File: rtl/watch_set_ctrl.sv
// watch_set_ctrl: RUN / SET time-set controller for the watch datapath.
// Turns debounced buttons and UART command bytes into single-cycle
// sec/min/hour plus pulses. Adds field selection and a set-mode
// inactivity timeout, and issues at most one plus pulse per cycle.
// Optional feature: define WATCH_SET_AUTOREPEAT_EN to compile in
// auto-repeat of the held up button.
// An ignored button (sel/up while in RUN) does not block a UART command.
module watch_set_ctrl #(
  parameter int CLK_FREQ      = 100_000_000,
  parameter int TIMEOUT_MS    = 10_000,
  parameter int RPT_DELAY_MS  = 500,
  parameter int RPT_PERIOD_MS = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_btn_mode,
  input  logic       i_btn_sel,
  input  logic       i_btn_up,
  input  logic       i_btn_up_lvl,
  input  logic       i_cmd_valid,
  input  logic [7:0] i_cmd_data,
  output logic       o_cmd_ready,
  output logic       o_sec_plus,
  output logic       o_min_plus,
  output logic       o_hour_plus,
  output logic       o_set_mode,
  output logic [1:0] o_sel
);

  localparam int PRESCALE = (CLK_FREQ / 1000 > 1) ? CLK_FREQ / 1000 : 1;
  localparam int PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int TO_W     = (TIMEOUT_MS > 1) ? $clog2(TIMEOUT_MS) : 1;

  localparam logic [7:0] CMD_SEC   = 8'h73;
  localparam logic [7:0] CMD_MIN   = 8'h6D;
  localparam logic [7:0] CMD_HOUR  = 8'h68;
  localparam logic [7:0] CMD_ENTER = 8'h65;
  localparam logic [7:0] CMD_EXIT  = 8'h78;

  // State encoding equals the o_sel field code, so o_sel comes straight off the state flops
  typedef enum logic [1:0] {
    SET_SEC  = 2'd0,
    SET_MIN  = 2'd1,
    SET_HOUR = 2'd2,
    RUN      = 2'd3
  } stateT;

  stateT            r_state;
  stateT            w_stateNext;
  logic [PRE_W-1:0] r_preCount;
  logic             w_msTick;
  logic [TO_W-1:0]  r_msCount;
  logic             w_inSet;
  logic             w_modeEvent;
  logic             w_selEvent;
  logic             w_upEvent;
  logic             w_rptFire;
  logic             w_btnBusy;
  logic             w_cmdAccept;
  logic             w_activity;
  logic             w_timeout;
  logic             w_secPlus;
  logic             w_minPlus;
  logic             w_hourPlus;
  logic             r_secPlus;
  logic             r_minPlus;
  logic             r_hourPlus;
  logic             r_cmdReady;
  logic             r_setMode;

  assign w_inSet     = (r_state != RUN);
  assign w_modeEvent = i_btn_mode;
  assign w_selEvent  = i_btn_sel & w_inSet & ~i_btn_mode;
  assign w_upEvent   = i_btn_up & w_inSet & ~i_btn_mode & ~i_btn_sel;
  assign w_btnBusy   = w_modeEvent | w_selEvent | w_upEvent | w_rptFire;
  assign w_cmdAccept = i_cmd_valid & ~w_btnBusy;
  assign w_activity  = w_btnBusy | w_cmdAccept;
  assign w_msTick    = (r_preCount == PRE_W'(PRESCALE - 1));
  assign w_timeout   = w_inSet & ~w_activity & w_msTick &
                       (r_msCount == TO_W'(TIMEOUT_MS - 1));

  // Free-running 1 ms timebase shared by the timeout and auto-repeat counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          r_preCount <= '0;
    else if (w_msTick) r_preCount <= '0;
    else               r_preCount <= r_preCount + 1'b1;
  end

`ifdef WATCH_SET_AUTOREPEAT_EN
  localparam int RPT_MAX = (RPT_DELAY_MS > RPT_PERIOD_MS) ? RPT_DELAY_MS : RPT_PERIOD_MS;
  localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

  logic             r_rptArmed;
  logic             r_rptFirst;
  logic [RPT_W-1:0] r_rptCount;
  logic [RPT_W-1:0] w_rptTerm;
  logic             w_rptHold;

  assign w_rptTerm = r_rptFirst ? RPT_W'(RPT_DELAY_MS - 1) : RPT_W'(RPT_PERIOD_MS - 1);
  assign w_rptHold = r_rptArmed & w_inSet & i_btn_up_lvl & ~w_modeEvent & ~w_selEvent & ~w_upEvent;
  assign w_rptFire = w_rptHold & w_msTick & (r_rptCount == w_rptTerm);

  // Auto-repeat: armed by an up press, counts ms while held, disarmed by anything that breaks the hold
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rptArmed <= 1'b0;
      r_rptFirst <= 1'b0;
      r_rptCount <= '0;
    end else if (w_upEvent) begin
      r_rptArmed <= 1'b1;
      r_rptFirst <= 1'b1;
      r_rptCount <= '0;
    end else if (!w_rptHold) begin
      r_rptArmed <= 1'b0;
      r_rptFirst <= 1'b0;
      r_rptCount <= '0;
    end else if (w_rptFire) begin
      r_rptFirst <= 1'b0;
      r_rptCount <= '0;
    end else if (w_msTick) begin
      r_rptCount <= r_rptCount + 1'b1;
    end
  end
`else
  localparam int RPT_UNUSED = RPT_DELAY_MS + RPT_PERIOD_MS;
  logic w_unusedLvl;
  assign w_unusedLvl = i_btn_up_lvl;
  assign w_rptFire   = 1'b0;
`endif

  // Next state and plus-pulse select: mode > sel > up > repeat > UART command > timeout
  always_comb begin
    w_stateNext = r_state;
    w_secPlus   = 1'b0;
    w_minPlus   = 1'b0;
    w_hourPlus  = 1'b0;
    if (w_modeEvent) begin
      w_stateNext = w_inSet ? RUN : SET_SEC;
    end else if (w_selEvent) begin
      case (r_state)
        SET_SEC: w_stateNext = SET_MIN;
        SET_MIN: w_stateNext = SET_HOUR;
        default: w_stateNext = SET_SEC;
      endcase
    end else if (w_upEvent || w_rptFire) begin
      case (r_state)
        SET_SEC:  w_secPlus  = 1'b1;
        SET_MIN:  w_minPlus  = 1'b1;
        SET_HOUR: w_hourPlus = 1'b1;
        default:  ;
      endcase
    end else if (w_cmdAccept) begin
      case (i_cmd_data)
        CMD_SEC:   w_secPlus  = 1'b1;
        CMD_MIN:   w_minPlus  = 1'b1;
        CMD_HOUR:  w_hourPlus = 1'b1;
        CMD_ENTER: if (!w_inSet) w_stateNext = SET_SEC;
        CMD_EXIT:  w_stateNext = RUN;
        default:   ;
      endcase
    end else if (w_timeout) begin
      w_stateNext = RUN;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= RUN;
    else      r_state <= w_stateNext;
  end

  // Inactivity counter: restarts on any activity, held at zero whenever the FSM is (or is going) to RUN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                   r_msCount <= '0;
    else if (w_stateNext == RUN || w_activity)  r_msCount <= '0;
    else if (w_msTick)                          r_msCount <= r_msCount + 1'b1;
  end

  // Registered outputs so the datapath sees clean single-cycle pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_secPlus  <= 1'b0;
      r_minPlus  <= 1'b0;
      r_hourPlus <= 1'b0;
      r_cmdReady <= 1'b0;
      r_setMode  <= 1'b0;
    end else begin
      r_secPlus  <= w_secPlus;
      r_minPlus  <= w_minPlus;
      r_hourPlus <= w_hourPlus;
      r_cmdReady <= w_cmdAccept;
      r_setMode  <= (w_stateNext != RUN);
    end
  end

  assign o_sec_plus  = r_secPlus;
  assign o_min_plus  = r_minPlus;
  assign o_hour_plus = r_hourPlus;
  assign o_cmd_ready = r_cmdReady;
  assign o_set_mode  = r_setMode;
  assign o_sel       = r_state;

endmodule
